port_deprioritizer_pipe: RTL and testbench

PORT_DEPRIORITIZER_PIPE -- requirements
Module: port_deprioritizer_pipe

---
 rtl/port_deprioritizer_pipe.sv | 110 +++++++++++
 tb/tb_port_deprioritizer_pipe.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/port_deprioritizer_pipe.sv
// Port deprioritizer pipe: routes each input lane to the output port named by
// its original-port ID, with lowest-lane-wins arbitration, a one-deep register
// slot per output port, and saturating collision/drop event counters.
module port_deprioritizer_pipe #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned NUM_PORTS = 3,
    parameter int unsigned ID_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PORTS*ID_W-1:0]    in_id,
    input  logic [NUM_PORTS*WIDTH-1:0]   in_data,
    input  logic [NUM_PORTS-1:0]         in_valid,
    output logic [NUM_PORTS-1:0]         in_ready,
    output logic [NUM_PORTS*WIDTH-1:0]   out_data,
    output logic [NUM_PORTS-1:0]         out_valid,
    input  logic [NUM_PORTS-1:0]         out_ready,
    input  logic                         clr_cnt,
    output logic [7:0]                   collision_cnt,
    output logic [7:0]                   drop_cnt
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(255);

    logic [ID_W-1:0]      lane_id  [NUM_PORTS];
    logic [ID_W-1:0]      tgt      [NUM_PORTS];
    logic [NUM_PORTS-1:0] id_ok;
    logic [NUM_PORTS-1:0] lost;
    logic [NUM_PORTS-1:0] slot_free;
    logic [NUM_PORTS-1:0] hit;
    logic [WIDTH-1:0]     win_data [NUM_PORTS];
    logic                 coll_any;
    logic                 drop_any;

    // Decode IDs, arbitrate per target port and derive ready/slot-load controls.
    always_comb begin
        in_ready = '0;
        id_ok    = '0;
        lost     = '0;
        hit      = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            slot_free[p] = !out_valid[p] || out_ready[p];
            win_data[p]  = '0;
        end
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            lane_id[i] = in_id[i*ID_W +: ID_W];
            id_ok[i]   = (lane_id[i] != '0) && (lane_id[i] <= ID_W'(NUM_PORTS));
            tgt[i]     = lane_id[i] - ID_W'(1);
        end
        // A lane loses only to a lower lane that is actually presenting a beat.
        for (int unsigned i = 1; i < NUM_PORTS; i++) begin
            for (int unsigned j = 0; j < i; j++) begin
                if (in_valid[j] && id_ok[j] && id_ok[i] && (tgt[j] == tgt[i]))
                    lost[i] = 1'b1;
            end
        end
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (!id_ok[i]) begin
                in_ready[i] = 1'b1;
            end else begin
                for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                    if (tgt[i] == ID_W'(p)) begin
                        in_ready[i] = !lost[i] && slot_free[p];
                        if (in_valid[i] && !lost[i] && slot_free[p]) begin
                            hit[p]      = 1'b1;
                            win_data[p] = in_data[i*WIDTH +: WIDTH];
                        end
                    end
                end
            end
        end
        coll_any = |(in_valid & lost);
        drop_any = |(in_valid & ~id_ok);
    end

    // Output slots: load on a winning transfer, drain when consumed, hold when stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (hit[p]) begin
                    out_data[p*WIDTH +: WIDTH] <= win_data[p];
                    out_valid[p]               <= 1'b1;
                end else if (out_ready[p]) begin
                    out_valid[p] <= 1'b0;
                end
            end
        end
    end

    // Saturating event counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            collision_cnt <= '0;
            drop_cnt      <= '0;
        end else if (clr_cnt) begin
            collision_cnt <= '0;
            drop_cnt      <= '0;
        end else begin
            if (coll_any && (collision_cnt != CNT_MAX))
                collision_cnt <= collision_cnt + CNT_W'(1);
            if (drop_any && (drop_cnt != CNT_MAX))
                drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_port_deprioritizer_pipe.sv
// Directed bench for port_deprioritizer_pipe (3 ports, 8-bit data, 2-bit IDs).
module tb_port_deprioritizer_pipe;

    localparam int unsigned WIDTH     = 8;
    localparam int unsigned NUM_PORTS = 3;
    localparam int unsigned ID_W      = 2;

    logic                       clk;
    logic                       rst_n;
    logic [NUM_PORTS*ID_W-1:0]  in_id;
    logic [NUM_PORTS*WIDTH-1:0] in_data;
    logic [NUM_PORTS-1:0]       in_valid;
    logic [NUM_PORTS-1:0]       in_ready;
    logic [NUM_PORTS*WIDTH-1:0] out_data;
    logic [NUM_PORTS-1:0]       out_valid;
    logic [NUM_PORTS-1:0]       out_ready;
    logic                       clr_cnt;
    logic [7:0]                 collision_cnt;
    logic [7:0]                 drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    port_deprioritizer_pipe #(
        .WIDTH(WIDTH), .NUM_PORTS(NUM_PORTS), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_id(in_id), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .clr_cnt(clr_cnt), .collision_cnt(collision_cnt), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_id = '0; in_data = '0; in_valid = '0;
        out_ready = 3'b111; clr_cnt = 1'b0;
        step(); step();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data",  32'(out_data), 32'h0);
        chk("rst_coll",      32'(collision_cnt), 32'h0);
        chk("rst_drop",      32'(drop_cnt), 32'h0);
        rst_n = 1'b1;
        step();

        // Identity routing
        in_id = {2'd3, 2'd2, 2'd1}; in_data = 24'h332211; in_valid = 3'b111;
        #1 chk("id_in_ready", 32'(in_ready), 32'h7);
        step();
        chk("id_out_data",  32'(out_data), 32'h332211);
        chk("id_out_valid", 32'(out_valid), 32'h7);

        // Permuted routing, back-to-back
        in_id = {2'd2, 2'd1, 2'd3}; in_data = 24'hC0B0A0;
        #1 chk("perm_in_ready", 32'(in_ready), 32'h7);
        step();
        chk("perm_out_data",  32'(out_data), 32'hA0C0B0);
        chk("perm_out_valid", 32'(out_valid), 32'h7);
        chk("perm_coll",      32'(collision_cnt), 32'h0);

        // Collision: lane0 and lane2 both target port1, lane1 idle
        in_id = {2'd2, 2'd1, 2'd2}; in_data = 24'h02EE01; in_valid = 3'b101;
        #1 chk("coll_rdy0", 32'(in_ready[0]), 32'h1);
        chk("coll_rdy2", 32'(in_ready[2]), 32'h0);
        step();
        chk("coll_first_data", 32'(out_data[15:8]), 32'h01);
        chk("coll_first_valid", 32'(out_valid), 32'h2);
        chk("coll_cnt1", 32'(collision_cnt), 32'h1);
        in_valid = 3'b100;
        #1 chk("coll_rdy2_win", 32'(in_ready[2]), 32'h1);
        step();
        chk("coll_second_data", 32'(out_data[15:8]), 32'h02);
        chk("coll_cnt_hold", 32'(collision_cnt), 32'h1);
        in_valid = 3'b000;
        step();
        chk("drain_valid", 32'(out_valid), 32'h0);

        // Backpressure on port0 with an independent port1 transfer
        in_id = {2'd3, 2'd2, 2'd1}; in_data = 24'h000055; in_valid = 3'b001;
        step();
        chk("bp_load", 32'(out_data[7:0]), 32'h55);
        out_ready = 3'b110; in_data = 24'h007766; in_valid = 3'b011;
        #1 chk("bp_rdy0", 32'(in_ready[0]), 32'h0);
        chk("bp_rdy1", 32'(in_ready[1]), 32'h1);
        step();
        chk("bp_hold_data", 32'(out_data[7:0]), 32'h55);
        chk("bp_hold_valid", 32'(out_valid[0]), 32'h1);
        chk("bp_indep_port1", 32'(out_data[15:8]), 32'h77);
        in_valid = 3'b001; out_ready = 3'b111;
        #1 chk("bp_rdy0_release", 32'(in_ready[0]), 32'h1);
        step();
        chk("bp_new_data", 32'(out_data[7:0]), 32'h66);
        chk("bp_new_valid", 32'(out_valid), 32'h1);
        in_valid = 3'b000;
        step();

        // Invalid ID on lane1 for 300 cycles saturates drop_cnt
        in_id = {2'd3, 2'd0, 2'd1}; in_data = 24'h00AB00; in_valid = 3'b010;
        #1 chk("inv_rdy1", 32'(in_ready[1]), 32'h1);
        for (int k = 0; k < 300; k++) step();
        chk("inv_drop_sat", 32'(drop_cnt), 32'hFF);
        chk("inv_no_output", 32'(out_valid), 32'h0);
        clr_cnt = 1'b1;
        step();
        chk("clr_priority", 32'(drop_cnt), 32'h0);
        chk("clr_coll", 32'(collision_cnt), 32'h0);
        clr_cnt = 1'b0;
        step();
        chk("drop_after_clr", 32'(drop_cnt), 32'h1);
        in_valid = 3'b000;

        // Reset mid-operation
        in_id = {2'd2, 2'd2, 2'd1}; in_data = 24'h0F0E0D; in_valid = 3'b111;
        step();
        in_valid = 3'b100;
        step();
        in_id = {2'd3, 2'd2, 2'd1}; in_valid = 3'b111;
        step();
        chk("pre_rst_valid", 32'(out_valid), 32'h7);
        chk("pre_rst_coll", 32'(collision_cnt), 32'h1);
        in_valid = 3'b000; out_ready = 3'b000;
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_data", 32'(out_data), 32'h0);
        chk("mid_rst_coll", 32'(collision_cnt), 32'h0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'h0);
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
